// File: rtl/ula_share_arbiter_if.sv
// Request/response/ULA bus between two requesters, the arbiter and the shared ULA.
// The arbiter uses the slave modport; the requesters plus ULA side uses master.
interface ula_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_err;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_err;

  logic [DATA_W-1:0] ula_a;
  logic [DATA_W-1:0] ula_b;
  logic [OP_W-1:0]   ula_op;
  logic [DATA_W-1:0] ula_result;
  logic              ula_flagz;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp0_ready,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  rsp1_ready,
    output ula_a, ula_b, ula_op,
    input  ula_result, ula_flagz
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp0_ready,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output rsp1_ready,
    input  ula_a, ula_b, ula_op,
    output ula_result, ula_flagz
  );
endinterface

// File: rtl/ula_share_arbiter.sv
// Round-robin sharing of one combinational ULA between two requesters,
// one transaction in flight: IDLE (grant) -> ISSUE (ULA settles) -> RESP (handshake).
module ula_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  ula_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q;
  logic              grant0, grant1;
  logic [DATA_W-1:0] ula_a_q, ula_b_q;
  logic [OP_W-1:0]   ula_op_q;
  logic [DATA_W-1:0] rsp0_result_q, rsp1_result_q;
  logic              rsp0_zero_q, rsp1_zero_q;
  logic              rsp0_err_q, rsp1_err_q;
  logic              op_ok;
  logic [DATA_W-1:0] cap_result;
  logic              cap_zero;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(4'b0000), OP_W'(4'b0001), OP_W'(4'b0010),
      OP_W'(4'b0110), OP_W'(4'b0111), OP_W'(4'b1100): op_supported = 1'b1;
      default:                                         op_supported = 1'b0;
    endcase
  endfunction

  // Grant is only meaningful in IDLE; pointer breaks ties (0 -> req0).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) grant0 = 1'b1;
      else if (bus.req1_valid)                           grant1 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d = ISSUE;
          ptr_d   = grant0;
        end
      end
      ISSUE:   state_d = RESP;
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  always_comb begin
    bus.req0_ready = rst_n & grant0;
    bus.req1_ready = rst_n & grant1;
    bus.rsp0_valid = (state_q == RESP) & ~owner_q;
    bus.rsp1_valid = (state_q == RESP) &  owner_q;
  end

  // Unsupported opcodes return an all-zero result with err set.
  always_comb begin
    op_ok      = op_supported(ula_op_q);
    cap_result = op_ok ? bus.ula_result : '0;
    cap_zero   = op_ok & bus.ula_flagz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= 1'b0;
      ula_a_q       <= '0;
      ula_b_q       <= '0;
      ula_op_q      <= '0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp0_err_q    <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
      rsp1_err_q    <= 1'b0;
    end else begin
      if (grant0) begin
        ula_a_q  <= bus.req0_a;
        ula_b_q  <= bus.req0_b;
        ula_op_q <= bus.req0_op;
        owner_q  <= 1'b0;
      end else if (grant1) begin
        ula_a_q  <= bus.req1_a;
        ula_b_q  <= bus.req1_b;
        ula_op_q <= bus.req1_op;
        owner_q  <= 1'b1;
      end
      if (state_q == ISSUE) begin
        if (!owner_q) begin
          rsp0_result_q <= cap_result;
          rsp0_zero_q   <= cap_zero;
          rsp0_err_q    <= ~op_ok;
        end else begin
          rsp1_result_q <= cap_result;
          rsp1_zero_q   <= cap_zero;
          rsp1_err_q    <= ~op_ok;
        end
      end
    end
  end

  assign bus.ula_a       = ula_a_q;
  assign bus.ula_b       = ula_b_q;
  assign bus.ula_op      = ula_op_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp0_zero   = rsp0_zero_q;
  assign bus.rsp0_err    = rsp0_err_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign bus.rsp1_zero   = rsp1_zero_q;
  assign bus.rsp1_err    = rsp1_err_q;

endmodule

// File: tb/tb_ula_share_arbiter.sv
// Scoreboard bench for ula_share_arbiter; the bench also plays the shared ULA.
module tb_ula_share_arbiter;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  typedef struct packed {
    logic              owner;
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ula_share_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  ula_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic op_sup(input logic [OP_W-1:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  endfunction

  // Unsupported codes produce a nonzero value and flagz=1 so forcing is visible.
  function automatic logic [DATA_W-1:0] ula_f(input logic [OP_W-1:0] op,
                                              input logic [DATA_W-1:0] a, b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1100: return ~(a | b);
      default: return a + b + 1;
    endcase
  endfunction

  function automatic exp_t mk(input logic owner, input logic [OP_W-1:0] op,
                              input logic [DATA_W-1:0] a, b);
    exp_t e;
    e.owner = owner;
    if (op_sup(op)) begin
      e.res = ula_f(op, a, b); e.zero = (e.res == 0); e.err = 1'b0;
    end else begin
      e.res = '0; e.zero = 1'b0; e.err = 1'b1;
    end
    return e;
  endfunction

  always_comb begin
    bus.ula_result = ula_f(bus.ula_op, bus.ula_a, bus.ula_b);
    bus.ula_flagz  = op_sup(bus.ula_op) ? (bus.ula_result == 0) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input logic owner, input logic [DATA_W-1:0] res,
                         input logic zero, input logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_rsp", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_owner", owner, e.owner);
      chk("rsp_result", res, e.res);
      chk("rsp_zero", zero, e.zero);
      chk("rsp_err", err, e.err);
    end
  endtask

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready)
        exp_q.push_back(mk(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
      if (bus.req1_valid && bus.req1_ready)
        exp_q.push_back(mk(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
      if (bus.req0_ready && bus.req1_ready) chk("ready_exclusive", 1, 0);
      if (bus.rsp0_valid && bus.rsp1_valid) chk("valid_exclusive", 1, 0);
      if (bus.rsp0_valid && bus.rsp0_ready)
        pop_chk(1'b0, bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err);
      if (bus.rsp1_valid && bus.rsp1_ready)
        pop_chk(1'b1, bus.rsp1_result, bus.rsp1_zero, bus.rsp1_err);
    end
  end

  task automatic drive(input int idx, input logic [DATA_W-1:0] a, b, input logic [OP_W-1:0] op);
    if (idx == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  task automatic wait_rdy(input int idx);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((idx == 0) ? bus.req0_ready : bus.req1_ready) return;
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int idx);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((idx == 0) ? bus.rsp0_valid : bus.rsp1_valid) return;
    end
    chk("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Single request: drive, wait for accept, drop valid, wait for response.
  task automatic one_txn(input int idx, input logic [DATA_W-1:0] a, b, input logic [OP_W-1:0] op);
    @(posedge clk); #1;
    drive(idx, a, b, op);
    wait_rdy(idx);
    @(posedge clk); #1;
    if (idx == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    wait_rsp(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[3];
    int n;
    logic [DATA_W-1:0] held;

    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;

    // Reset with random request traffic
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(0, $urandom, $urandom, 4'($urandom_range(0, 15)));
      drive(1, $urandom, $urandom, 4'($urandom_range(0, 15)));
      @(negedge clk);
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
      chk("rst_ula", {bus.ula_a, bus.ula_b, bus.ula_op}, 0);
    end
    chk("rst_rsp_fields", {bus.rsp0_result, bus.rsp0_zero, bus.rsp0_err,
                           bus.rsp1_result[30:0], bus.rsp1_zero, bus.rsp1_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_req0", bus.req0_ready, 1);
    chk("first_grant_not_req1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rdy(1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    // Contention: both valid continuously, expect req0, req1, req0
    @(posedge clk); #1;
    drive(0, 9, 9, 4'b0110);
    drive(1, 32'hF0, 32'h0F, 4'b0001);
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin order[n] = 0; n++; end
      else if (bus.req1_ready) begin order[n] = 1; n++; end
      if (bus.rsp0_valid) begin
        chk("rr_rsp0_result", bus.rsp0_result, 0);
        chk("rr_rsp0_zero", bus.rsp0_zero, 1);
      end
      if (bus.rsp1_valid) begin
        chk("rr_rsp1_result", bus.rsp1_result, 32'hFF);
        chk("rr_rsp1_zero", bus.rsp1_zero, 0);
      end
    end
    chk("rr_grants", n, 3);
    chk("rr_order", {order[0][0], order[1][0], order[2][0]}, 3'b010);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain();

    // Single ADD with cycle-exact latency
    @(posedge clk); #1;
    drive(0, 5, 7, 4'b0010);
    wait_rdy(0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("add_ula_op", bus.ula_op, 4'b0010);
    chk("add_ula_ab", {bus.ula_a, bus.ula_b}, {32'd5, 32'd7});
    chk("add_not_yet_valid", bus.rsp0_valid, 0);
    @(negedge clk);
    chk("add_rsp0_valid", bus.rsp0_valid, 1);
    chk("add_result", bus.rsp0_result, 12);
    chk("add_zero_err", {bus.rsp0_zero, bus.rsp0_err}, 2'b00);
    drain();

    // Response backpressure on req1 while req0 waits
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b0;
    drive(1, 1, 2, 4'b0010);
    wait_rdy(1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drive(0, 4, 4, 4'b0110);
    wait_rsp(1);
    held = bus.rsp1_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp1_valid", bus.rsp1_valid, 1);
      chk("bp_rsp1_result", bus.rsp1_result, 3);
      chk("bp_rsp1_stable", bus.rsp1_result, held);
      chk("bp_req0_ready", bus.req0_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b1;
    wait_rdy(0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    drain();

    // Unsupported opcode, then a supported one on the same requester
    one_txn(1, 3, 4, 4'b1111);
    chk("inv_err", bus.rsp1_err, 1);
    chk("inv_result", bus.rsp1_result, 0);
    chk("inv_zero", bus.rsp1_zero, 0);
    drain();
    one_txn(1, 3, 4, 4'b0010);
    chk("valid_op_err", bus.rsp1_err, 0);
    chk("valid_op_result", bus.rsp1_result, 7);
    drain();

    // Reset asserted while a req0 response is pending
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    drive(0, 1, 1, 4'b0010);
    wait_rdy(0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rsp(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp0_valid", bus.rsp0_valid, 0);
    chk("midrst_rsp0_result", bus.rsp0_result, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    end
    @(posedge clk); #1;
    drive(0, 2, 3, 4'b0000);
    drive(1, 2, 3, 4'b0001);
    @(negedge clk);
    chk("midrst_ptr_req0", bus.req0_ready, 1);
    chk("midrst_ptr_not_req1", bus.req1_ready, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_rdy(1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
